// File: rtl/scr_bod_protect_monitor.sv
// SCR breakover-diode protection monitor.
// Counts BOD firing events within a window that opens on the first event,
// forbids trigger pulses for a fixed lockout time when too many occur, and
// escalates to a sticky fault after repeated lockouts or an SCR state
// conflict. Also keeps saturating per-direction BOD totals for status.
module scr_bod_protect_monitor #(
  parameter int WINDOW_CYCLES  = 50000,
  parameter int BOD_LIMIT      = 3,
  parameter int LOCKOUT_CYCLES = 500000,
  parameter int TRIP_LIMIT     = 3,
  parameter int CNT_W          = 8
) (
  input  logic             i_clk_50m,
  input  logic             i_rst,
  input  logic             i_SCR_forward_state,
  input  logic             i_SCR_negative_state,
  input  logic             i_SCR_forward_BOD,
  input  logic             i_SCR_negative_BOD,
  input  logic             i_clear,
  output logic             o_signal_forbid,
  output logic             o_fault_forward,
  output logic             o_fault_negative,
  output logic             o_conflict,
  output logic [CNT_W-1:0] o_bod_cnt_forward,
  output logic [CNT_W-1:0] o_bod_cnt_negative,
  output logic [1:0]       o_state
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WINDOW  = 2'd1;
  localparam logic [1:0] ST_LOCKOUT = 2'd2;
  localparam logic [1:0] ST_FAULT   = 2'd3;

  // Timer widths follow their own terminal counts; a width of at least 1 keeps
  // degenerate parameter choices legal.
  localparam int WIN_TW = (WINDOW_CYCLES > 1)  ? $clog2(WINDOW_CYCLES)  : 1;
  localparam int LCK_TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  // Window count spans 0..BOD_LIMIT.
  localparam int WC_W   = $clog2(BOD_LIMIT + 1);
  // Lockout count reaches TRIP_LIMIT on the escalating trip.
  localparam int LC_W   = $clog2(TRIP_LIMIT + 1);
  // Sum of window count plus up to two events in one cycle.
  localparam int SUM_W  = WC_W + 2;

  localparam logic [WIN_TW-1:0] WIN_LAST  = WIN_TW'(WINDOW_CYCLES - 1);
  localparam logic [LCK_TW-1:0] LCK_LAST  = LCK_TW'(LOCKOUT_CYCLES - 1);
  localparam logic [SUM_W-1:0]  SUM_LIMIT = SUM_W'(BOD_LIMIT);
  localparam logic [LC_W-1:0]   LC_ESC    = LC_W'(TRIP_LIMIT - 1);
  localparam logic [LC_W-1:0]   LC_MAX    = {LC_W{1'b1}};

  // Saturating event counter; a clear in the same cycle as an event loads 1.
  function automatic logic [CNT_W-1:0] cnt_upd(input logic [CNT_W-1:0] cur,
                                               input logic ev,
                                               input logic clr);
    logic [CNT_W-1:0] base;
    base = clr ? {CNT_W{1'b0}} : cur;
    if (ev && (base != {CNT_W{1'b1}})) begin
      cnt_upd = base + CNT_W'(1);
    end else begin
      cnt_upd = base;
    end
  endfunction

  logic              prev_fwd_r;
  logic              prev_neg_r;
  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [WIN_TW-1:0] win_timer_r;
  logic [WIN_TW-1:0] win_timer_nxt_s;
  logic [LCK_TW-1:0] lck_timer_r;
  logic [LCK_TW-1:0] lck_timer_nxt_s;
  logic [WC_W-1:0]   win_cnt_r;
  logic [WC_W-1:0]   win_cnt_nxt_s;
  logic              win_dir_fwd_r;
  logic              win_dir_fwd_nxt_s;
  logic              win_dir_neg_r;
  logic              win_dir_neg_nxt_s;
  logic [LC_W-1:0]   lockout_cnt_r;
  logic [LC_W-1:0]   lockout_cnt_nxt_s;
  logic              fault_fwd_r;
  logic              fault_fwd_nxt_s;
  logic              fault_neg_r;
  logic              fault_neg_nxt_s;
  logic              conflict_r;
  logic              conflict_nxt_s;
  logic [CNT_W-1:0]  cnt_fwd_r;
  logic [CNT_W-1:0]  cnt_fwd_nxt_s;
  logic [CNT_W-1:0]  cnt_neg_r;
  logic [CNT_W-1:0]  cnt_neg_nxt_s;
  logic              forbid_r;
  logic              forbid_nxt_s;

  logic              ev_fwd_s;
  logic              ev_neg_s;
  logic [1:0]        ev_num_s;
  logic              conflict_s;
  logic              clear_s;
  logic [LC_W-1:0]   lc_base_s;
  logic [SUM_W-1:0]  sum_s;

  // Rising-edge detection on the BOD levels and qualification of clear.
  always_comb begin
    ev_fwd_s   = i_SCR_forward_BOD & ~prev_fwd_r;
    ev_neg_s   = i_SCR_negative_BOD & ~prev_neg_r;
    ev_num_s   = {1'b0, ev_fwd_s} + {1'b0, ev_neg_s};
    conflict_s = i_SCR_forward_state & i_SCR_negative_state;
    // A conflict in the same cycle wins over clear entirely.
    clear_s    = i_clear & ~conflict_s;
    lc_base_s  = clear_s ? {LC_W{1'b0}} : lockout_cnt_r;
    sum_s      = {2'b00, win_cnt_r} + SUM_W'(ev_num_s);
  end

  // Next-state logic for the protection FSM, timers, counters and flags.
  always_comb begin
    state_nxt_s       = state_r;
    win_timer_nxt_s   = win_timer_r;
    lck_timer_nxt_s   = lck_timer_r;
    win_cnt_nxt_s     = win_cnt_r;
    win_dir_fwd_nxt_s = win_dir_fwd_r;
    win_dir_neg_nxt_s = win_dir_neg_r;
    lockout_cnt_nxt_s = lc_base_s;
    cnt_fwd_nxt_s     = cnt_upd(cnt_fwd_r, ev_fwd_s, clear_s);
    cnt_neg_nxt_s     = cnt_upd(cnt_neg_r, ev_neg_s, clear_s);
    if (clear_s) begin
      fault_fwd_nxt_s = 1'b0;
      fault_neg_nxt_s = 1'b0;
      conflict_nxt_s  = 1'b0;
    end else begin
      fault_fwd_nxt_s = fault_fwd_r;
      fault_neg_nxt_s = fault_neg_r;
      conflict_nxt_s  = conflict_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (ev_num_s != 2'd0) begin
          state_nxt_s       = ST_WINDOW;
          win_timer_nxt_s   = {WIN_TW{1'b0}};
          win_cnt_nxt_s     = WC_W'(ev_num_s);
          win_dir_fwd_nxt_s = ev_fwd_s;
          win_dir_neg_nxt_s = ev_neg_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WINDOW: begin
        if (sum_s >= SUM_LIMIT) begin
          // Flag every direction that fired during this window.
          fault_fwd_nxt_s   = fault_fwd_nxt_s | win_dir_fwd_r | ev_fwd_s;
          fault_neg_nxt_s   = fault_neg_nxt_s | win_dir_neg_r | ev_neg_s;
          state_nxt_s       = (lc_base_s == LC_ESC) ? ST_FAULT : ST_LOCKOUT;
          if (lc_base_s != LC_MAX) begin
            lockout_cnt_nxt_s = lc_base_s + LC_W'(1);
          end else begin
            lockout_cnt_nxt_s = lc_base_s;
          end
          lck_timer_nxt_s   = {LCK_TW{1'b0}};
          win_timer_nxt_s   = {WIN_TW{1'b0}};
          win_cnt_nxt_s     = {WC_W{1'b0}};
          win_dir_fwd_nxt_s = 1'b0;
          win_dir_neg_nxt_s = 1'b0;
        end else if (win_timer_r == WIN_LAST) begin
          state_nxt_s       = ST_IDLE;
          win_timer_nxt_s   = {WIN_TW{1'b0}};
          win_cnt_nxt_s     = {WC_W{1'b0}};
          win_dir_fwd_nxt_s = 1'b0;
          win_dir_neg_nxt_s = 1'b0;
        end else begin
          win_timer_nxt_s   = win_timer_r + WIN_TW'(1);
          win_cnt_nxt_s     = sum_s[WC_W-1:0];
          win_dir_fwd_nxt_s = win_dir_fwd_r | ev_fwd_s;
          win_dir_neg_nxt_s = win_dir_neg_r | ev_neg_s;
        end
      end
      ST_LOCKOUT: begin
        if (lck_timer_r == LCK_LAST) begin
          state_nxt_s     = ST_IDLE;
          lck_timer_nxt_s = {LCK_TW{1'b0}};
        end else begin
          lck_timer_nxt_s = lck_timer_r + LCK_TW'(1);
        end
      end
      ST_FAULT: begin
        if (clear_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_FAULT;
        end
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        win_timer_nxt_s = {WIN_TW{1'b0}};
        lck_timer_nxt_s = {LCK_TW{1'b0}};
        win_cnt_nxt_s   = {WC_W{1'b0}};
      end
    endcase

    // Both SCRs conducting at once is unsafe: latch it and force FAULT.
    if (conflict_s) begin
      conflict_nxt_s    = 1'b1;
      state_nxt_s       = ST_FAULT;
      win_timer_nxt_s   = {WIN_TW{1'b0}};
      lck_timer_nxt_s   = {LCK_TW{1'b0}};
      win_cnt_nxt_s     = {WC_W{1'b0}};
      win_dir_fwd_nxt_s = 1'b0;
      win_dir_neg_nxt_s = 1'b0;
    end else begin
      conflict_nxt_s = conflict_nxt_s;
    end

    forbid_nxt_s = (state_nxt_s == ST_LOCKOUT) || (state_nxt_s == ST_FAULT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk_50m) begin
    if (i_rst) begin
      prev_fwd_r    <= 1'b0;
      prev_neg_r    <= 1'b0;
      state_r       <= ST_IDLE;
      win_timer_r   <= {WIN_TW{1'b0}};
      lck_timer_r   <= {LCK_TW{1'b0}};
      win_cnt_r     <= {WC_W{1'b0}};
      win_dir_fwd_r <= 1'b0;
      win_dir_neg_r <= 1'b0;
      lockout_cnt_r <= {LC_W{1'b0}};
      fault_fwd_r   <= 1'b0;
      fault_neg_r   <= 1'b0;
      conflict_r    <= 1'b0;
      cnt_fwd_r     <= {CNT_W{1'b0}};
      cnt_neg_r     <= {CNT_W{1'b0}};
      forbid_r      <= 1'b0;
    end else begin
      prev_fwd_r    <= i_SCR_forward_BOD;
      prev_neg_r    <= i_SCR_negative_BOD;
      state_r       <= state_nxt_s;
      win_timer_r   <= win_timer_nxt_s;
      lck_timer_r   <= lck_timer_nxt_s;
      win_cnt_r     <= win_cnt_nxt_s;
      win_dir_fwd_r <= win_dir_fwd_nxt_s;
      win_dir_neg_r <= win_dir_neg_nxt_s;
      lockout_cnt_r <= lockout_cnt_nxt_s;
      fault_fwd_r   <= fault_fwd_nxt_s;
      fault_neg_r   <= fault_neg_nxt_s;
      conflict_r    <= conflict_nxt_s;
      cnt_fwd_r     <= cnt_fwd_nxt_s;
      cnt_neg_r     <= cnt_neg_nxt_s;
      forbid_r      <= forbid_nxt_s;
    end
  end

  assign o_signal_forbid    = forbid_r;
  assign o_fault_forward    = fault_fwd_r;
  assign o_fault_negative   = fault_neg_r;
  assign o_conflict         = conflict_r;
  assign o_bod_cnt_forward  = cnt_fwd_r;
  assign o_bod_cnt_negative = cnt_neg_r;
  assign o_state            = state_r;

endmodule

// File: tb/tb_scr_bod_protect_monitor.sv
// Self-checking bench for scr_bod_protect_monitor with small parameters.
module tb_scr_bod_protect_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fs = 1'b0, ns = 1'b0, fb = 1'b0, nb = 1'b0, clr = 1'b0;

  logic       forbid, ff, fn, conf;
  logic [3:0] cf, cn;
  logic [1:0] st;
  logic       forbid2, ff2, fn2, conf2;
  logic [3:0] cf2, cn2;
  logic [1:0] st2;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  scr_bod_protect_monitor #(.WINDOW_CYCLES(20), .BOD_LIMIT(3), .LOCKOUT_CYCLES(10),
                            .TRIP_LIMIT(2), .CNT_W(4)) dut (
    .i_clk_50m(clk), .i_rst(rst),
    .i_SCR_forward_state(fs), .i_SCR_negative_state(ns),
    .i_SCR_forward_BOD(fb), .i_SCR_negative_BOD(nb), .i_clear(clr),
    .o_signal_forbid(forbid), .o_fault_forward(ff), .o_fault_negative(fn),
    .o_conflict(conf), .o_bod_cnt_forward(cf), .o_bod_cnt_negative(cn), .o_state(st));

  scr_bod_protect_monitor #(.WINDOW_CYCLES(20), .BOD_LIMIT(100), .LOCKOUT_CYCLES(10),
                            .TRIP_LIMIT(2), .CNT_W(4)) dut_sat (
    .i_clk_50m(clk), .i_rst(rst),
    .i_SCR_forward_state(fs), .i_SCR_negative_state(ns),
    .i_SCR_forward_BOD(fb), .i_SCR_negative_BOD(nb), .i_clear(clr),
    .o_signal_forbid(forbid2), .o_fault_forward(ff2), .o_fault_negative(fn2),
    .o_conflict(conf2), .o_bod_cnt_forward(cf2), .o_bod_cnt_negative(cn2), .o_state(st2));

  typedef struct {
    logic fs, ns, fb, nb, clr, rst;
    int   cyc;
    bit   chk;
    int   e_st, e_forbid, e_ff, e_fn, e_conf, e_cf, e_cn;
  } seg_t;

  typedef struct {
    int e_st, e_forbid, e_ff, e_fn, e_conf, e_cf, e_cn;
  } exp_t;

  seg_t tbl[$];
  exp_t sb[$];
  int   hq[$];

  task automatic add(input logic a_fs, a_ns, a_fb, a_nb, a_clr, a_rst, input int cyc,
                     input bit chk, input int e_st, e_forbid, e_ff, e_fn, e_conf, e_cf, e_cn);
    seg_t s;
    s.fs = a_fs; s.ns = a_ns; s.fb = a_fb; s.nb = a_nb; s.clr = a_clr; s.rst = a_rst;
    s.cyc = cyc; s.chk = chk;
    s.e_st = e_st; s.e_forbid = e_forbid; s.e_ff = e_ff; s.e_fn = e_fn;
    s.e_conf = e_conf; s.e_cf = e_cf; s.e_cn = e_cn;
    tbl.push_back(s);
  endtask

  // Three forward pulses 4 cycles apart; the last row checks the trip result.
  task automatic add_trip(input int e_st, input int e_cf);
    add(0,0,1,0,0,0, 1, 0, 0,0,0,0,0,0,0);
    add(0,0,0,0,0,0, 3, 0, 0,0,0,0,0,0,0);
    add(0,0,1,0,0,0, 1, 0, 0,0,0,0,0,0,0);
    add(0,0,0,0,0,0, 3, 0, 0,0,0,0,0,0,0);
    add(0,0,1,0,0,0, 1, 1, e_st,1,1,0,0,e_cf,0);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    // reset
    add(0,0,0,0,0,1, 2, 1, 0,0,0,0,0,0,0);
    // single 5-cycle forward pulse: window lasts exactly 20 cycles
    add(0,0,1,0,0,0, 5, 1, 1,0,0,0,0,1,0);
    add(0,0,0,0,0,0,15, 1, 1,0,0,0,0,1,0);
    add(0,0,0,0,0,0, 1, 1, 0,0,0,0,0,1,0);
    // three pulses -> lockout for 10 cycles
    add(0,0,1,0,0,0, 1, 1, 1,0,0,0,0,2,0);
    add(0,0,0,0,0,0, 3, 0, 0,0,0,0,0,0,0);
    add(0,0,1,0,0,0, 1, 1, 1,0,0,0,0,3,0);
    add(0,0,0,0,0,0, 3, 0, 0,0,0,0,0,0,0);
    add(0,0,1,0,0,0, 1, 1, 2,1,1,0,0,4,0);
    add(0,0,0,0,0,0, 9, 1, 2,1,1,0,0,4,0);
    add(0,0,0,0,0,0, 1, 1, 0,0,1,0,0,4,0);
    // second trip escalates to FAULT; clear recovers and resets lockout count
    add(0,0,0,0,0,1, 2, 1, 0,0,0,0,0,0,0);
    add_trip(2, 3);
    add(0,0,0,0,0,0,10, 1, 0,0,1,0,0,3,0);
    add_trip(3, 6);
    add(0,0,0,0,0,0,30, 1, 3,1,1,0,0,6,0);
    add(0,0,0,0,1,0, 1, 1, 0,0,0,0,0,0,0);
    add_trip(2, 3);
    add(0,0,0,0,0,0,10, 1, 0,0,1,0,0,3,0);
    // simultaneous pair counts 2
    add(0,0,0,0,0,1, 2, 1, 0,0,0,0,0,0,0);
    add(0,0,1,1,0,0, 1, 1, 1,0,0,0,0,1,1);
    add(0,0,0,0,0,0, 2, 0, 0,0,0,0,0,0,0);
    add(0,0,1,0,0,0, 1, 1, 2,1,1,1,0,2,1);
    add(0,0,0,0,0,0,10, 1, 0,0,1,1,0,2,1);
    // clear with an event in the same cycle loads 1
    add(0,0,1,0,1,0, 1, 1, 1,0,0,0,0,1,0);
    add(0,0,0,0,0,0,25, 1, 0,0,0,0,0,1,0);
    // conflict wins over a simultaneous clear
    add(0,0,0,0,0,1, 2, 1, 0,0,0,0,0,0,0);
    add(0,0,1,0,0,0, 1, 1, 1,0,0,0,0,1,0);
    add(1,1,0,0,1,0, 1, 1, 3,1,0,0,1,1,0);
    add(0,0,0,0,0,0, 5, 1, 3,1,0,0,1,1,0);
    add(0,0,0,0,1,0, 1, 1, 0,0,0,0,0,0,0);

    foreach (tbl[i]) begin
      exp_t e;
      fs = tbl[i].fs; ns = tbl[i].ns; fb = tbl[i].fb; nb = tbl[i].nb;
      clr = tbl[i].clr; rst = tbl[i].rst;
      if (tbl[i].chk) begin
        e.e_st = tbl[i].e_st; e.e_forbid = tbl[i].e_forbid; e.e_ff = tbl[i].e_ff;
        e.e_fn = tbl[i].e_fn; e.e_conf = tbl[i].e_conf; e.e_cf = tbl[i].e_cf;
        e.e_cn = tbl[i].e_cn;
        sb.push_back(e);
      end
      step(tbl[i].cyc);
      if (tbl[i].chk) begin
        e = sb.pop_front();
        check($sformatf("seg%0d_state", i), int'(st), e.e_st);
        check($sformatf("seg%0d_forbid", i), int'(forbid), e.e_forbid);
        check($sformatf("seg%0d_fault_fwd", i), int'(ff), e.e_ff);
        check($sformatf("seg%0d_fault_neg", i), int'(fn), e.e_fn);
        check($sformatf("seg%0d_conflict", i), int'(conf), e.e_conf);
        check($sformatf("seg%0d_cnt_fwd", i), int'(cf), e.e_cf);
        check($sformatf("seg%0d_cnt_neg", i), int'(cn), e.e_cn);
      end
    end
    fs = 1'b0; ns = 1'b0; fb = 1'b0; nb = 1'b0; clr = 1'b0; rst = 1'b0;

    // Window length: count cycles spent in WINDOW after one pulse.
    begin
      int n;
      hq.push_back(20);
      fb = 1'b1; step(1); fb = 1'b0;
      n = 0;
      for (int i = 0; i < 100 && st == 2'd1; i++) begin
        n++;
        step(1);
      end
      check("window_len", n, hq.pop_front());
    end

    // Lockout length: count forbid-high cycles after a trip.
    begin
      int n;
      hq.push_back(10);
      fb = 1'b1; step(1); fb = 1'b0; step(3);
      fb = 1'b1; step(1); fb = 1'b0; step(3);
      fb = 1'b1; step(1); fb = 1'b0;
      n = 0;
      for (int i = 0; i < 100 && forbid == 1'b1; i++) begin
        n++;
        step(1);
      end
      check("lockout_len", n, hq.pop_front());
    end

    // Saturation with a high BOD limit, then reset mid-window.
    begin
      int seen_forbid;
      rst = 1'b1; step(2); rst = 1'b0;
      seen_forbid = 0;
      for (int i = 0; i < 20; i++) begin
        fb = 1'b1; step(1);
        if (forbid2) seen_forbid = 1;
        fb = 1'b0; step(1);
        if (forbid2) seen_forbid = 1;
      end
      hq.push_back(15); hq.push_back(1); hq.push_back(0);
      check("sat_cnt_fwd", int'(cf2), hq.pop_front());
      check("sat_state_mid", int'(st2), hq.pop_front());
      check("sat_no_forbid", seen_forbid, hq.pop_front());
      rst = 1'b1;
      hq.push_back(0); hq.push_back(0); hq.push_back(0);
      step(1);
      check("sat_rst_state", int'(st2), hq.pop_front());
      check("sat_rst_cnt", int'(cf2), hq.pop_front());
      check("sat_rst_forbid", int'(forbid2), hq.pop_front());
      rst = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/scr_bod_protect_monitor.md
Name: scr_bod_protect_monitor

Overview:
- Downstream of counter_6bits: consumes its SCR conduction-state and BOD (breakover-diode firing) flags.
- Counts BOD events within a sliding-start time window and asserts a timed trigger-pulse lockout when too many occur.
- Escalates to a sticky fault after repeated lockouts.
- o_signal_forbid drives counter_6bits i_signal_forbid.
- Also provides cumulative per-direction BOD counters for status readout.

Parameters:
WINDOW_CYCLES, 50000, observation window length in clocks (1 ms at 50 MHz).
BOD_LIMIT, 3, BOD events within one window that trigger a lockout.
LOCKOUT_CYCLES, 500000, lockout duration in clocks (10 ms).
TRIP_LIMIT, 3, lockout count that escalates to FAULT instead of LOCKOUT.
CNT_W, 8, width of cumulative BOD counters.

Ports:
i_clk_50m  in  1  system clock, 50 MHz
i_rst  in  1  synchronous reset, active-high
i_SCR_forward_state  in  1  forward SCR conducting (from counter_6bits)
i_SCR_negative_state  in  1  negative SCR conducting
i_SCR_forward_BOD  in  1  forward BOD flag (level)
i_SCR_negative_BOD  in  1  negative BOD flag (level)
i_clear  in  1  one-cycle clear pulse
o_signal_forbid  out  1  trigger-pulse forbid, high in LOCKOUT and FAULT
o_fault_forward  out  1  sticky: forward BOD contributed to a trip
o_fault_negative  out  1  sticky: negative BOD contributed to a trip
o_conflict  out  1  sticky: both SCR states seen high together
o_bod_cnt_forward  out  CNT_W  cumulative forward BOD rising edges, saturating
o_bod_cnt_negative  out  CNT_W  cumulative negative BOD rising edges, saturating
o_state  out  2  0 IDLE, 1 WINDOW, 2 LOCKOUT, 3 FAULT

Behaviour:
- All logic on the rising edge of i_clk_50m. i_rst forces IDLE, clears all timers and counters, and drives every output to 0.
- Edge detection: a BOD event is a sample of 1 when the previous sample was 0. The previous-sample registers reset to 0, so an input already high at reset release counts as an event.
- State, counter and output updates happen at the same edge the event is sampled. o_signal_forbid rises at that edge (latency 0 registered cycles).
- Cumulative counters increment on every edge event in every state and saturate at 2^CNT_W-1. Simultaneous forward and negative events each increment their own counter.
- Window count: 0..BOD_LIMIT, counts forward plus negative events. A simultaneous pair adds 2.
- IDLE: on any event -> WINDOW, timer=0, window count = number of events this cycle.
- WINDOW:
  - Timer increments each cycle.
  - Events add to the window count.
  - If the count reaches or exceeds BOD_LIMIT:
    - Set o_fault_* for each direction that had an event during this window.
    - If lockout_cnt == TRIP_LIMIT-1 -> FAULT, else -> LOCKOUT. lockout_cnt increments in both cases.
  - Else, when the timer reaches WINDOW_CYCLES-1 -> IDLE and the window count clears.
- LOCKOUT:
  - o_signal_forbid=1, timer counts 0..LOCKOUT_CYCLES-1, then -> IDLE.
  - Events update only the cumulative counters.
- FAULT:
  - o_signal_forbid=1, held indefinitely.
  - Exit only via i_clear -> IDLE.
- Conflict: if i_SCR_forward_state and i_SCR_negative_state are both 1 in any state, set o_conflict and go to FAULT immediately. This has priority over i_clear in the same cycle.
- i_clear (any state, no conflict):
  - Clears cumulative counters, o_fault_*, o_conflict and lockout_cnt.
  - FAULT -> IDLE.
  - Other states keep their state and timers.
  - An event in the same cycle: the cleared counter loads 1.
- lockout_cnt is cleared only by i_clear or i_rst and does not decay.
- Timers are sized by $clog2 of their parameter.

Test Plan (WINDOW_CYCLES=20, BOD_LIMIT=3, LOCKOUT_CYCLES=10, TRIP_LIMIT=2, CNT_W=4):
1. Reset, then one 5-cycle forward BOD pulse.
   - o_state=1 for 20 cycles, then 0.
   - o_bod_cnt_forward=1, o_signal_forbid stays 0.
2. Three 1-cycle forward pulses 4 cycles apart.
   - Forbid rises at the 3rd pulse edge and holds exactly 10 cycles.
   - o_state 2 then 0, o_fault_forward=1.
3. Repeat scenario 2 twice, no clear.
   - Second trip enters o_state=3 and forbid stays high.
   - i_clear pulse -> o_state=0, forbid=0, counters and flags 0.
4. Forward and negative pulses together, then one forward pulse.
   - Window count 3 -> LOCKOUT.
   - o_fault_forward=o_fault_negative=1, cnt_forward=2, cnt_negative=1.
5. Both SCR state inputs high for 1 cycle during WINDOW, with i_clear asserted in the same cycle.
   - o_conflict=1, o_state=3, forbid=1.
6. 20 forward pulses with BOD_LIMIT raised to 100.
   - o_bod_cnt_forward saturates at 15.
   - i_rst mid-window clears everything and o_state=0.
